// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file writeback block and the units that feed it.
package regfile_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DW      = 32;

    typedef enum logic {
        FILE_INT = 1'b0,
        FILE_FP  = 1'b1
    } file_sel_e;

    // Result record as carried from the long-latency units to writeback.
    typedef struct packed {
        logic                  fp;
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DW-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results. A push while full is taken
// only when a pop happens on the same edge.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback: arbitrates integer results (priority) and queued
// long-latency results onto the single write port, and keeps the pending
// scoreboard used by decode for RAW/WAW stalls.
// Optional macro REGFILE_WB_BYPASS_EN: a result arriving to an empty FIFO
// with no integer traffic is written directly, skipping the FIFO.
import regfile_writeback_pkg::*;

module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic          iss_fp,
    input  logic [4:0]    iss_rd,
    output logic          iss_ready,
    input  logic          chk_fp,
    input  logic [4:0]    chk_rs,
    input  logic [4:0]    chk_rt,
    output logic          stall,
    input  logic          int_valid,
    input  logic [4:0]    int_rd,
    input  logic [DW-1:0] int_data,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic          res_fp,
    input  logic [4:0]    res_rd,
    input  logic [DW-1:0] res_data,
    output logic          wr_en,
    output logic          wr_fp,
    output logic [4:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          err_waw
);

    localparam int EW = 1 + REG_ADDR_W + DW;

    typedef struct packed {
        logic                  fp;
        logic [REG_ADDR_W-1:0] rd;
        logic [DW-1:0]         data;
    } entry_t;

    logic [NUM_REGS-1:0] pend_int, pend_fp;
    logic [NUM_REGS-1:0] pend_int_n, pend_fp_n;
    entry_t              in_e, head_e, ret_e;
    logic [EW-1:0]       fifo_din, fifo_dout;
    logic                fifo_full, fifo_empty;
    logic                accept, bypass, push, pop, retire, iss_set;

    assign in_e      = '{fp: res_fp, rd: res_rd, data: res_data};
    assign fifo_din  = in_e;
    assign head_e    = entry_t'(fifo_dout);

    assign res_ready = ~fifo_full;
    assign accept    = res_valid & res_ready;
`ifdef REGFILE_WB_BYPASS_EN
    assign bypass    = accept & fifo_empty & ~int_valid;
`else
    assign bypass    = 1'b0;
`endif
    assign push      = accept & ~bypass;
    assign pop       = ~int_valid & ~fifo_empty;
    assign retire    = pop | bypass;
    assign ret_e     = pop ? head_e : in_e;

    assign iss_ready = ~(iss_fp ? pend_fp[iss_rd] : pend_int[iss_rd]);
    assign iss_set   = iss_valid & iss_ready & (iss_fp | (iss_rd != 5'd0));
    assign stall     = chk_fp ? (pend_fp[chk_rs]  | pend_fp[chk_rt])
                              : (pend_int[chk_rs] | pend_int[chk_rt]);

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Scoreboard next state: retire clears first, a same-edge reservation wins.
    always_comb begin
        pend_int_n = pend_int;
        pend_fp_n  = pend_fp;
        if (retire) begin
            if (ret_e.fp == FILE_FP) pend_fp_n[ret_e.rd]  = 1'b0;
            else                     pend_int_n[ret_e.rd] = 1'b0;
        end
        if (iss_set) begin
            if (iss_fp == FILE_FP) pend_fp_n[iss_rd]  = 1'b1;
            else                   pend_int_n[iss_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_int <= '0;
            pend_fp  <= '0;
        end else begin
            pend_int <= pend_int_n;
            pend_fp  <= pend_fp_n;
        end
    end

    // Write-port arbiter; integer results always win, int r0 never strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_fp   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (int_valid) begin
            wr_en   <= (int_rd != 5'd0);
            wr_fp   <= FILE_INT;
            wr_addr <= int_rd;
            wr_data <= int_data;
        end else if (retire) begin
            wr_en   <= (ret_e.fp == FILE_FP) | (ret_e.rd != 5'd0);
            wr_fp   <= ret_e.fp;
            wr_addr <= ret_e.rd;
            wr_data <= ret_e.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Sticky flag: an integer result landed on a register still awaiting a long-latency result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_waw <= 1'b0;
        end else if (int_valid && (int_rd != 5'd0) && pend_int[int_rd]) begin
            err_waw <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_fp;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        chk_fp;
    logic [4:0]  chk_rs, chk_rt;
    logic        stall;
    logic        int_valid;
    logic [4:0]  int_rd;
    logic [31:0] int_data;
    logic        res_valid, res_ready, res_fp;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        wr_en, wr_fp;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err_waw;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(4), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_fp(iss_fp), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_fp(chk_fp), .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall),
        .int_valid(int_valid), .int_rd(int_rd), .int_data(int_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_fp(res_fp),
        .res_rd(res_rd), .res_data(res_data),
        .wr_en(wr_en), .wr_fp(wr_fp), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_waw(err_waw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iss_valid = 0; iss_fp = 0; iss_rd = 0;
        chk_fp = 0; chk_rs = 0; chk_rt = 0;
        int_valid = 0; int_rd = 0; int_data = 0;
        res_valid = 0; res_fp = 0; res_rd = 0; res_data = 0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_fp", wr_fp, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_waw", err_waw, 0);
        check("rst_res_ready", res_ready, 1);
        check("rst_iss_ready", iss_ready, 1);
        check("rst_stall", stall, 0);

        // Integer result: one-cycle latency.
        int_valid = 1; int_rd = 5'd5; int_data = 32'hDEADBEEF;
        step();
        int_valid = 0;
        check("int_wr_en", wr_en, 1);
        check("int_wr_fp", wr_fp, 0);
        check("int_wr_addr", wr_addr, 5);
        check("int_wr_data", wr_data, 32'hDEADBEEF);
        step();
        check("idle_wr_en", wr_en, 0);
        check("idle_addr_hold", wr_addr, 5);
        check("idle_data_hold", wr_data, 32'hDEADBEEF);

        // FP reservation, stall, and result latency.
        iss_valid = 1; iss_fp = 1; iss_rd = 5'd3;
        chk_fp = 1; chk_rs = 5'd3; chk_rt = 5'd0;
        #1;
        check("iss_fp3_ready", iss_ready, 1);
        step();
        iss_valid = 0;
        #1;
        check("fp3_stall", stall, 1);
        check("fp3_iss_ready_busy", iss_ready, 0);
        chk_fp = 0;
        #1;
        check("int3_no_stall", stall, 0);
        chk_fp = 1;
        res_valid = 1; res_fp = 1; res_rd = 5'd3; res_data = 32'h3F800000;
        #1;
        check("res_ready_fp3", res_ready, 1);
        step();
        res_valid = 0;
`ifdef REGFILE_WB_BYPASS_EN
        check("fp3_byp_wr_en", wr_en, 1);
        check("fp3_byp_wr_fp", wr_fp, 1);
        check("fp3_byp_wr_addr", wr_addr, 3);
        check("fp3_byp_wr_data", wr_data, 32'h3F800000);
        check("fp3_byp_stall", stall, 0);
        step();
        check("fp3_byp_after", wr_en, 0);
`else
        check("fp3_n1_wr_en", wr_en, 0);
        check("fp3_n1_stall", stall, 1);
        step();
        check("fp3_wr_en", wr_en, 1);
        check("fp3_wr_fp", wr_fp, 1);
        check("fp3_wr_addr", wr_addr, 3);
        check("fp3_wr_data", wr_data, 32'h3F800000);
        check("fp3_stall_clear", stall, 0);
`endif
        step();
        check("fp3_done", wr_en, 0);

        // Fill FIFO while integer traffic blocks the write port.
        int_valid = 1; int_rd = 5'd1; int_data = 32'h11;
        res_valid = 1; res_fp = 0;
        for (int i = 0; i < 4; i++) begin
            res_rd = 5'(10 + i);
            res_data = 32'hA0 + i;
            #1;
            check("fill_res_ready", res_ready, 1);
            step();
            check("fill_int_wr_addr", wr_addr, 1);
            check("fill_int_wr_en", wr_en, 1);
        end
        res_valid = 0;
        #1;
        check("full_res_ready", res_ready, 0);
        int_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_wr_en", wr_en, 1);
            check("drain_wr_fp", wr_fp, 0);
            check("drain_wr_addr", wr_addr, 10 + i);
            check("drain_wr_data", wr_data, 32'hA0 + i);
        end
        check("drain_res_ready", res_ready, 1);
        step();
        check("drain_done", wr_en, 0);

        // WAW on int r7.
        iss_valid = 1; iss_fp = 0; iss_rd = 5'd7;
        #1;
        check("iss7_first_ready", iss_ready, 1);
        step();
        check("iss7_second_ready", iss_ready, 0);
        iss_valid = 0;
        int_valid = 1; int_rd = 5'd7; int_data = 32'h77;
        step();
        int_valid = 0;
        check("waw_wr_en", wr_en, 1);
        check("waw_wr_addr", wr_addr, 7);
        check("waw_wr_data", wr_data, 32'h77);
        check("waw_err", err_waw, 1);
        step();
        check("waw_err_sticky", err_waw, 1);

        // Int r0 is hardwired.
        int_valid = 1; int_rd = 5'd0; int_data = 32'h1;
        step();
        int_valid = 0;
        check("r0_no_wr_en", wr_en, 0);
        iss_valid = 1; iss_fp = 0; iss_rd = 5'd0;
        step();
        iss_valid = 0;
        chk_fp = 0; chk_rs = 5'd0; chk_rt = 5'd0;
        #1;
        check("r0_no_stall", stall, 0);

        // Reset with queued results and reservations outstanding.
        iss_valid = 1; iss_fp = 1; iss_rd = 5'd20;
        step();
        iss_rd = 5'd21;
        step();
        iss_valid = 0;
        int_valid = 1; int_rd = 5'd2; int_data = 32'h22;
        res_valid = 1; res_fp = 1; res_rd = 5'd20; res_data = 32'h200;
        step();
        res_rd = 5'd21; res_data = 32'h210;
        step();
        chk_fp = 1; chk_rs = 5'd20; chk_rt = 5'd21;
        #1;
        check("pre_rst_stall", stall, 1);
        res_valid = 0; int_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_res_ready", res_ready, 1);
        check("mid_rst_err_waw", err_waw, 0);
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 32; r++) begin
                chk_fp = f[0]; chk_rs = 5'(r); chk_rt = 5'(r);
                #1;
                check("mid_rst_stall", stall, 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_rst_no_write", wr_en, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
